// File: rtl/efx_ram_arbiter_pkg.sv
// Shared widths, FSM state and read-owner encoding for the RAM arbiter.
package efx_ram_arbiter_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 256;

  // Arbiter top-level state: CLEAR zeroes the RAM, RUN serves requesters.
  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  // Which requester owns a granted access.
  typedef enum logic {
    OWN_A = 1'b0,
    OWN_B = 1'b1
  } owner_t;

endpackage

// File: rtl/efx_ram_arbiter_if.sv
// Requester and RAM-primitive signals of the arbiter.
// Handshake: a requester holds REQ/WE/ADDR/WDATA until it sees GNT high in
// the same cycle; GNT is combinational, so REQ & GNT at a rising edge means
// the access was taken. Reads return RDATA qualified by a one-cycle RVALID.
interface efx_ram_arbiter_if;
  import efx_ram_arbiter_pkg::*;

  logic              A_REQ,    B_REQ;
  logic              A_WE,     B_WE;
  logic [ADDR_W-1:0] A_ADDR,   B_ADDR;
  logic [DATA_W-1:0] A_WDATA,  B_WDATA;
  logic              A_GNT,    B_GNT;
  logic              A_RVALID, B_RVALID;
  logic [DATA_W-1:0] A_RDATA,  B_RDATA;

  logic [ADDR_W-1:0] RAM_WADDR;
  logic [DATA_W-1:0] RAM_WDATA;
  logic              RAM_WE;
  logic              RAM_WCLKE;
  logic [ADDR_W-1:0] RAM_RADDR;
  logic              RAM_RE;
  logic [DATA_W-1:0] RAM_RDATA;

  // Arbiter side.
  modport slave (
    input  A_REQ, B_REQ, A_WE, B_WE, A_ADDR, B_ADDR, A_WDATA, B_WDATA,
    output A_GNT, B_GNT, A_RVALID, B_RVALID, A_RDATA, B_RDATA,
    output RAM_WADDR, RAM_WDATA, RAM_WE, RAM_WCLKE, RAM_RADDR, RAM_RE,
    input  RAM_RDATA
  );

  // Requesters plus RAM primitive side.
  modport master (
    output A_REQ, B_REQ, A_WE, B_WE, A_ADDR, B_ADDR, A_WDATA, B_WDATA,
    input  A_GNT, B_GNT, A_RVALID, B_RVALID, A_RDATA, B_RDATA,
    input  RAM_WADDR, RAM_WDATA, RAM_WE, RAM_WCLKE, RAM_RADDR, RAM_RE,
    output RAM_RDATA
  );
endinterface

// File: rtl/efx_rr_arb2.sv
// Two-input round-robin arbiter. A lone request is always granted; on
// contention the requester not granted last time wins. The pointer only
// moves on a grant and resets to "B last" so A wins the first contention.
module efx_rr_arb2
  import efx_ram_arbiter_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic req_a_i,
  input  logic req_b_i,
  output logic gnt_a_o,
  output logic gnt_b_o
);

  owner_t last_q;

  // Grant decision from the requests and the last-winner pointer.
  always_comb begin
    gnt_a_o = req_a_i & (~req_b_i | (last_q == OWN_B));
    gnt_b_o = req_b_i & (~req_a_i | (last_q == OWN_A));
  end

  // Remember the most recent winner.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_q <= OWN_B;
    end else if (gnt_a_o) begin
      last_q <= OWN_A;
    end else if (gnt_b_o) begin
      last_q <= OWN_B;
    end
  end

endmodule

// File: rtl/efx_ram_arbiter.sv
// Two-requester arbiter in front of a 256x16 RAM with independent write and
// read ports. Optionally zeroes the RAM after reset, then grants at most one
// write and one read per cycle, each port round-robin on contention.
module efx_ram_arbiter
  import efx_ram_arbiter_pkg::*;
#(
  parameter int READ_LAT       = 1,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic               CLK,
  input  logic               SR,
  efx_ram_arbiter_if.slave   bus,
  output logic               BUSY,
  output state_t             dbg_state_o
);

  state_t            state_q;
  logic [ADDR_W-1:0] cnt_q;
  logic              run_en;
  logic              clearing;
  logic              a_wgnt, b_wgnt, a_rgnt, b_rgnt;
  logic [READ_LAT-1:0] vld_q;
  owner_t            own_q [READ_LAT];

  assign run_en   = (state_q == RUN) & ~SR;
  assign clearing = (state_q == CLEAR) & ~SR;

  efx_rr_arb2 u_warb (
    .clk_i   (CLK),
    .rst_i   (SR),
    .req_a_i (bus.A_REQ & bus.A_WE & run_en),
    .req_b_i (bus.B_REQ & bus.B_WE & run_en),
    .gnt_a_o (a_wgnt),
    .gnt_b_o (b_wgnt)
  );

  efx_rr_arb2 u_rarb (
    .clk_i   (CLK),
    .rst_i   (SR),
    .req_a_i (bus.A_REQ & ~bus.A_WE & run_en),
    .req_b_i (bus.B_REQ & ~bus.B_WE & run_en),
    .gnt_a_o (a_rgnt),
    .gnt_b_o (b_rgnt)
  );

  // Control FSM: walk the clear counter through every address, then serve.
  always_ff @(posedge CLK) begin
    if (SR) begin
      state_q <= CLEAR_ON_RESET ? CLEAR : RUN;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        CLEAR: begin
          cnt_q <= cnt_q + 8'd1;
          if (cnt_q == 8'hFF) begin
            state_q <= RUN;
          end
        end
        default: begin
          state_q <= RUN;
        end
      endcase
    end
  end

  // Read tag pipeline: tracks which requester owns each in-flight read so
  // its RVALID fires exactly READ_LAT cycles after the grant.
  always_ff @(posedge CLK) begin
    if (SR) begin
      vld_q <= '0;
      for (int i = 0; i < READ_LAT; i++) begin
        own_q[i] <= OWN_A;
      end
    end else begin
      vld_q[0] <= a_rgnt | b_rgnt;
      own_q[0] <= b_rgnt ? OWN_B : OWN_A;
      for (int i = 1; i < READ_LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        own_q[i] <= own_q[i-1];
      end
    end
  end

  // Write port: clear sequence owns it in CLEAR, the write winner in RUN.
  always_comb begin
    bus.RAM_WE    = clearing | a_wgnt | b_wgnt;
    bus.RAM_WCLKE = clearing | a_wgnt | b_wgnt;
    if (clearing) begin
      bus.RAM_WADDR = cnt_q;
      bus.RAM_WDATA = '0;
    end else if (b_wgnt) begin
      bus.RAM_WADDR = bus.B_ADDR;
      bus.RAM_WDATA = bus.B_WDATA;
    end else begin
      bus.RAM_WADDR = bus.A_ADDR;
      bus.RAM_WDATA = bus.A_WDATA;
    end
  end

  // Read port, grants, returned data and status.
  always_comb begin
    bus.RAM_RE    = a_rgnt | b_rgnt;
    bus.RAM_RADDR = b_rgnt ? bus.B_ADDR : bus.A_ADDR;
    bus.A_GNT     = a_wgnt | a_rgnt;
    bus.B_GNT     = b_wgnt | b_rgnt;
    bus.A_RDATA   = bus.RAM_RDATA;
    bus.B_RDATA   = bus.RAM_RDATA;
    bus.A_RVALID  = vld_q[READ_LAT-1] & (own_q[READ_LAT-1] == OWN_A) & ~SR;
    bus.B_RVALID  = vld_q[READ_LAT-1] & (own_q[READ_LAT-1] == OWN_B) & ~SR;
    BUSY          = SR ? CLEAR_ON_RESET : (state_q == CLEAR);
    dbg_state_o   = state_q;
  end

endmodule

// File: tb/tb_efx_ram_arbiter.sv
// Directed bench for efx_ram_arbiter: u_dut1 uses READ_LAT=1 with clear on
// reset, u_dut2 uses READ_LAT=2 without clear. Each has a behavioural
// READ_FIRST 256x16 RAM model.
module tb_efx_ram_arbiter;
  import efx_ram_arbiter_pkg::*;

  logic   clk = 1'b0;
  logic   sr1, sr2;
  logic   busy1, busy2;
  state_t dbg1, dbg2;
  int     n_total = 0;
  int     n_bad   = 0;

  efx_ram_arbiter_if bus1 ();
  efx_ram_arbiter_if bus2 ();

  always #5 clk = ~clk;

  efx_ram_arbiter #(.READ_LAT(1), .CLEAR_ON_RESET(1'b1)) u_dut1 (
    .CLK(clk), .SR(sr1), .bus(bus1.slave), .BUSY(busy1), .dbg_state_o(dbg1)
  );

  efx_ram_arbiter #(.READ_LAT(2), .CLEAR_ON_RESET(1'b0)) u_dut2 (
    .CLK(clk), .SR(sr2), .bus(bus2.slave), .BUSY(busy2), .dbg_state_o(dbg2)
  );

  // RAM models (read-before-write on the same edge)
  logic [15:0] mem1 [256];
  logic [15:0] mem2 [256];
  logic [15:0] rd1_q, rd2a_q, rd2b_q;

  always @(posedge clk) begin
    if (bus1.RAM_WE && bus1.RAM_WCLKE) mem1[bus1.RAM_WADDR] <= bus1.RAM_WDATA;
    if (bus1.RAM_RE) rd1_q <= mem1[bus1.RAM_RADDR];
    if (bus2.RAM_WE && bus2.RAM_WCLKE) mem2[bus2.RAM_WADDR] <= bus2.RAM_WDATA;
    if (bus2.RAM_RE) rd2a_q <= mem2[bus2.RAM_RADDR];
    rd2b_q <= rd2a_q;
  end

  assign bus1.RAM_RDATA = rd1_q;
  assign bus2.RAM_RDATA = rd2b_q;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_a1(input logic req, input logic we, input logic [7:0] addr, input logic [15:0] wd);
    bus1.A_REQ = req; bus1.A_WE = we; bus1.A_ADDR = addr; bus1.A_WDATA = wd;
  endtask

  task automatic set_b1(input logic req, input logic we, input logic [7:0] addr, input logic [15:0] wd);
    bus1.B_REQ = req; bus1.B_WE = we; bus1.B_ADDR = addr; bus1.B_WDATA = wd;
  endtask

  task automatic set_a2(input logic req, input logic we, input logic [7:0] addr, input logic [15:0] wd);
    bus2.A_REQ = req; bus2.A_WE = we; bus2.A_ADDR = addr; bus2.A_WDATA = wd;
  endtask

  task automatic set_b2(input logic req, input logic we, input logic [7:0] addr, input logic [15:0] wd);
    bus2.B_REQ = req; bus2.B_WE = we; bus2.B_ADDR = addr; bus2.B_WDATA = wd;
  endtask

  // Called in the first window after SR falls. Requests (A read 05, B write
  // 06) are held through the clear and must be granted only once it ends.
  task automatic clear_check(input string tag);
    set_a1(1'b1, 1'b0, 8'h05, 16'h0000);
    set_b1(1'b1, 1'b1, 8'h06, 16'hC0DE);
    for (int i = 0; i < 256; i++) begin
      logic [7:0] ea;
      ea = 8'(i);
      @(negedge clk);
      chk(tag, {3'b0, busy1, bus1.RAM_WE, bus1.RAM_WCLKE, bus1.RAM_RE,
                bus1.A_GNT, bus1.RAM_WADDR, bus1.RAM_WDATA},
               {3'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, ea, 16'h0000});
      step();
    end
    @(negedge clk);
    chk({tag, "_done_busy"}, {31'b0, busy1}, 32'd0);
    chk({tag, "_done_state"}, {31'b0, dbg1}, {31'b0, RUN});
    chk({tag, "_done_gnt"}, {bus1.A_GNT, bus1.B_GNT, bus1.RAM_RE, bus1.RAM_WE,
                             bus1.RAM_RADDR, bus1.RAM_WADDR},
                            {1'b1, 1'b1, 1'b1, 1'b1, 8'h05, 8'h06});
    step();
    set_a1(1'b0, 1'b0, 8'h00, 16'h0000);
    set_b1(1'b0, 1'b0, 8'h00, 16'h0000);
    @(negedge clk);
    chk({tag, "_rd_zero"}, {bus1.A_RVALID, bus1.B_RVALID, bus1.A_RDATA},
                           {1'b1, 1'b0, 16'h0000});
    step();
  endtask

  initial begin
    sr1 = 1'b1;
    sr2 = 1'b1;
    set_a1(1'b1, 1'b0, 8'h05, 16'h0);
    set_b1(1'b1, 1'b1, 8'h06, 16'hC0DE);
    set_a2(1'b0, 1'b0, 8'h00, 16'h0);
    set_b2(1'b0, 1'b0, 8'h00, 16'h0);
    step();
    step();

    // ---------- reset values while SR is high ----------
    @(negedge clk);
    chk("rst1_outputs", {busy1, bus1.A_GNT, bus1.B_GNT, bus1.RAM_WE, bus1.RAM_WCLKE,
                         bus1.RAM_RE, bus1.A_RVALID, bus1.B_RVALID}, 32'h80);
    chk("rst2_busy", {31'b0, busy2}, 32'd0);
    step();
    sr1 = 1'b0;
    clear_check("clear1");

    // ---------- both write continuously: A,B,A,B ----------
    set_a1(1'b1, 1'b1, 8'h40, 16'hAAAA);
    set_b1(1'b1, 1'b1, 8'h41, 16'hBBBB);
    for (int i = 0; i < 4; i++) begin
      logic [7:0] ea;
      logic       ga;
      ga = (i % 2 == 0);
      ea = ga ? 8'h40 : 8'h41;
      @(negedge clk);
      chk("wr_rr", {bus1.A_GNT, bus1.B_GNT, bus1.RAM_WE, bus1.RAM_WADDR},
                   {ga, ~ga, 1'b1, ea});
      step();
    end
    set_a1(1'b0, 1'b0, 8'h00, 16'h0);
    set_b1(1'b0, 1'b0, 8'h00, 16'h0);

    // ---------- A writes BEEF to 10, B reads 10 ----------
    set_a1(1'b1, 1'b1, 8'h10, 16'hBEEF);
    @(negedge clk);
    chk("beef_wr", {bus1.A_GNT, bus1.RAM_WE, bus1.RAM_WADDR, bus1.RAM_WDATA},
                   {1'b1, 1'b1, 8'h10, 16'hBEEF});
    step();
    set_a1(1'b0, 1'b0, 8'h00, 16'h0);
    set_b1(1'b1, 1'b0, 8'h10, 16'h0);
    @(negedge clk);
    chk("beef_rd", {bus1.B_GNT, bus1.RAM_RE, bus1.RAM_WE, bus1.RAM_RADDR},
                   {1'b1, 1'b1, 1'b0, 8'h10});
    step();
    set_b1(1'b0, 1'b0, 8'h00, 16'h0);
    @(negedge clk);
    chk("beef_rv", {bus1.A_RVALID, bus1.B_RVALID, bus1.B_RDATA}, {1'b0, 1'b1, 16'hBEEF});
    step();
    @(negedge clk);
    chk("beef_rv_once", {bus1.A_RVALID, bus1.B_RVALID}, 32'd0);

    // ---------- same-address read and write: old data first ----------
    set_a1(1'b1, 1'b1, 8'h20, 16'h5555);
    step();
    set_a1(1'b1, 1'b0, 8'h20, 16'h0);
    set_b1(1'b1, 1'b1, 8'h20, 16'h1234);
    @(negedge clk);
    chk("rw_same_gnt", {bus1.A_GNT, bus1.B_GNT, bus1.RAM_RE, bus1.RAM_WE,
                        bus1.RAM_RADDR, bus1.RAM_WADDR},
                       {1'b1, 1'b1, 1'b1, 1'b1, 8'h20, 8'h20});
    step();
    set_b1(1'b0, 1'b0, 8'h00, 16'h0);
    @(negedge clk);
    chk("rw_same_old", {bus1.A_RVALID, bus1.A_RDATA}, {1'b1, 16'h5555});
    step();
    set_a1(1'b0, 1'b0, 8'h00, 16'h0);
    @(negedge clk);
    chk("rw_same_new", {bus1.A_RVALID, bus1.A_RDATA}, {1'b1, 16'h1234});
    step();

    // ---------- read contention: A read last, so B wins first ----------
    set_a1(1'b1, 1'b0, 8'h10, 16'h0);
    set_b1(1'b1, 1'b0, 8'h41, 16'h0);
    @(negedge clk);
    chk("rd_rr_b", {bus1.A_GNT, bus1.B_GNT, bus1.RAM_RADDR}, {1'b0, 1'b1, 8'h41});
    step();
    set_b1(1'b0, 1'b0, 8'h00, 16'h0);
    @(negedge clk);
    chk("rd_rr_a", {bus1.A_GNT, bus1.RAM_RADDR}, {1'b1, 8'h10});
    chk("rd_rr_bdata", {bus1.B_RVALID, bus1.A_RVALID, bus1.B_RDATA}, {1'b1, 1'b0, 16'hBBBB});
    step();
    set_a1(1'b0, 1'b0, 8'h00, 16'h0);
    @(negedge clk);
    chk("rd_rr_adata", {bus1.A_RVALID, bus1.B_RVALID, bus1.A_RDATA}, {1'b1, 1'b0, 16'hBEEF});
    step();

    // ---------- SR pulse at clear address 100 restarts the clear ----------
    sr1 = 1'b1;
    step();
    sr1 = 1'b0;
    for (int i = 0; i < 100; i++) step();
    @(negedge clk);
    chk("clr100_addr", {bus1.RAM_WE, bus1.RAM_WADDR}, {1'b1, 8'd100});
    sr1 = 1'b1;
    #1;
    chk("clr100_sr", {busy1, bus1.RAM_WE, bus1.RAM_WCLKE, bus1.A_GNT}, 32'h8);
    @(posedge clk);
    #1;
    sr1 = 1'b0;
    clear_check("clear2");

    // ---------- READ_LAT=2 instance ----------
    sr2 = 1'b0;
    @(negedge clk);
    chk("l2_run", {busy2, dbg2}, {1'b0, RUN});
    set_a2(1'b1, 1'b1, 8'h30, 16'h7777);
    @(negedge clk);
    chk("l2_wr", {bus2.A_GNT, bus2.RAM_WE, bus2.RAM_WADDR}, {1'b1, 1'b1, 8'h30});
    step();
    set_a2(1'b0, 1'b0, 8'h00, 16'h0);
    set_b2(1'b1, 1'b0, 8'h30, 16'h0);
    @(negedge clk);
    chk("l2_rd", {bus2.B_GNT, bus2.RAM_RE}, {1'b1, 1'b1});
    step();
    set_b2(1'b0, 1'b0, 8'h00, 16'h0);
    @(negedge clk);
    chk("l2_rv_early", {bus2.A_RVALID, bus2.B_RVALID}, 32'd0);
    step();
    @(negedge clk);
    chk("l2_rv", {bus2.A_RVALID, bus2.B_RVALID, bus2.B_RDATA}, {1'b0, 1'b1, 16'h7777});
    step();
    @(negedge clk);
    chk("l2_rv_once", {bus2.A_RVALID, bus2.B_RVALID}, 32'd0);

    // A read followed by SR: the in-flight read must be dropped.
    set_a2(1'b1, 1'b0, 8'h30, 16'h0);
    @(negedge clk);
    chk("l2_flush_gnt", {31'b0, bus2.A_GNT}, 32'd1);
    step();
    set_a2(1'b0, 1'b0, 8'h00, 16'h0);
    sr2 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("l2_flush_rv", {bus2.A_RVALID, bus2.B_RVALID}, 32'd0);
      step();
      sr2 = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
